// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter in front of sync_fifo
//
// Purpose:
//   Lets NUM_REQ producers share the single write port of sync_fifo. A
//   decision is taken at a rising edge when a request is pending and the
//   FIFO is not full. The write pulse (gnt/fifo_wr_en/fifo_data_in) appears
//   one cycle later and lasts one cycle. No decision is taken during that
//   cycle, so fifo_full already reflects the previous write at the next
//   decision. All outputs are registered.
//
// Optional feature:
//   FIFO_ARB_FIXED_PRIO_EN - when defined, req_i[0] always has highest
//   priority and the round-robin pointer register is removed.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   req_i          per-producer request level, held until its grant
//   req_data_i     packed producer data, slice i = [i*DATA_W +: DATA_W]
//   fifo_full_i    full flag from sync_fifo
//   gnt_o          one-hot single-cycle grant pulse
//   fifo_wr_en_o   write strobe to sync_fifo
//   fifo_data_in_o write data to sync_fifo
//   stall_o        request pending while the FIFO is full
//   wr_count_o     wrapping count of accepted writes

module fifo_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 4,
  parameter int WCNT_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic                      fifo_full_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_data_in_o,
  output logic                      stall_o,
  output logic [WCNT_W-1:0]         wr_count_o
);

  // NUM_REQ is limited to 2..4, so one or two pointer bits suffice.
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   win_idx;
  logic               found;
  logic               any_req;
  logic               do_grant;
  logic [NUM_REQ-1:0] gnt_d;
  logic [DATA_W-1:0]  data_d;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  assign ptr   = ptr_q;
  // Pointer moves to the port just after the winner, wrapping at NUM_REQ-1.
  assign ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else if (do_grant) begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Winner = first set request scanning upward from the pointer with wrap.
  always_comb begin
    any_req  = |req_i;
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_i[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Decode the winner with constant indices only.
  always_comb begin
    gnt_d  = '0;
    data_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        gnt_d[k] = 1'b1;
        data_d   = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // IDLE and STALL arbitrate identically; GRANT is the mandatory gap cycle.
  assign do_grant = ((state_q == IDLE) || (state_q == STALL)) &&
                    any_req && !fifo_full_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      gnt_o          <= '0;
      fifo_wr_en_o   <= 1'b0;
      fifo_data_in_o <= '0;
      stall_o        <= 1'b0;
      wr_count_o     <= '0;
    end else begin
      case (state_q)
        IDLE, STALL: begin
          if (do_grant) begin
            state_q        <= GRANT;
            gnt_o          <= gnt_d;
            fifo_wr_en_o   <= 1'b1;
            fifo_data_in_o <= data_d;
            stall_o        <= 1'b0;
            wr_count_o     <= wr_count_o + 1'b1;
          end else if (any_req) begin
            state_q      <= STALL;
            gnt_o        <= '0;
            fifo_wr_en_o <= 1'b0;
            stall_o      <= 1'b1;
          end else begin
            state_q      <= IDLE;
            gnt_o        <= '0;
            fifo_wr_en_o <= 1'b0;
            stall_o      <= 1'b0;
          end
        end
        GRANT: begin
          state_q      <= IDLE;
          gnt_o        <= '0;
          fifo_wr_en_o <= 1'b0;
          stall_o      <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          gnt_o        <= '0;
          fifo_wr_en_o <= 1'b0;
          stall_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 4;
  localparam int WCNT_W  = 8;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic                      full = 1'b0;
  logic [NUM_REQ-1:0]        gnt;
  logic                      wr_en;
  logic [DATA_W-1:0]         data_in;
  logic                      stall;
  logic [WCNT_W-1:0]         wr_count;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .WCNT_W (WCNT_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         (req),
    .req_data_i    (req_data),
    .fifo_full_i   (full),
    .gnt_o         (gnt),
    .fifo_wr_en_o  (wr_en),
    .fifo_data_in_o(data_in),
    .stall_o       (stall),
    .wr_count_o    (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic               wr;
    logic [DATA_W-1:0]  data;
    logic               stall;
    logic [WCNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  int               m_ptr  = 0;
  logic [WCNT_W-1:0] m_cnt = '0;
  bit               m_busy = 1'b0;
  int               m_w;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, want, $time);
    end
  endtask

  // Lowest set index at or above p, else lowest set index overall.
  function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int i = p; i < NUM_REQ; i++) if (r[i]) return i;
    for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
    return 0;
  endfunction

  // Reference model: predicts what the outputs show during the cycle that
  // follows each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_ptr  = 0;
      m_cnt  = '0;
      m_busy = 1'b0;
    end else begin
      m_e.gnt   = '0;
      m_e.wr    = 1'b0;
      m_e.data  = '0;
      m_e.stall = 1'b0;
      if (m_busy) begin
        m_busy = 1'b0;
      end else if (req != '0) begin
        if (!full) begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
          m_w = pick(req, 0);
`else
          m_w = pick(req, m_ptr);
          m_ptr = (m_w + 1) % NUM_REQ;
`endif
          m_e.gnt  = NUM_REQ'(1) << m_w;
          m_e.wr   = 1'b1;
          m_e.data = req_data[m_w*DATA_W +: DATA_W];
          m_cnt    = m_cnt + 1'b1;
          m_busy   = 1'b1;
        end else begin
          m_e.stall = 1'b1;
        end
      end
      m_e.cnt = m_cnt;
      exp_q.push_back(m_e);
    end
  end

  // Monitor: compares the outputs presented in each cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 0, 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("gnt", int'(gnt), int'(mon_e.gnt));
        chk("wr_en", int'(wr_en), int'(mon_e.wr));
        chk("stall", int'(stall), int'(mon_e.stall));
        chk("wr_count", int'(wr_count), int'(mon_e.cnt));
        if (mon_e.wr) chk("data_in", int'(data_in), int'(mon_e.data));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic set_data(input int i, input logic [DATA_W-1:0] v);
    req_data[i*DATA_W +: DATA_W] = v;
  endtask

  // Producers: hold request and data until granted, then drop or re-request.
  task automatic rand_drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && gnt[i]) begin
        if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
        else set_data(i, DATA_W'($urandom));
      end else if (!req[i]) begin
        if ($urandom_range(1, 0) == 1) begin
          req[i] = 1'b1;
          set_data(i, DATA_W'($urandom));
        end
      end else if ($urandom_range(15, 0) == 0) begin
        req[i] = 1'b0;
      end
    end
    full = ($urandom_range(3, 0) == 0);
  endtask

  bit seen;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_data", int'(data_in), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_count", int'(wr_count), 0);
    #2 reset = 1'b0;

    // Single request from port 0
    set_data(0, 4'h5);
    req = 2'b01;
    step();
    req = 2'b00;
    repeat (3) step();

    // Both ports held: alternating grants
    set_data(0, 4'h3);
    set_data(1, 4'hA);
    req = 2'b11;
    repeat (8) step();
    req = 2'b00;
    repeat (2) step();

    // Stall while full, then release
    full = 1'b1;
    req  = 2'b10;
    repeat (5) step();
    full = 1'b0;
    repeat (2) step();
    req = 2'b00;
    repeat (2) step();

    // Counter wrap: 260 grants from port 0
    set_data(0, 4'h7);
    req = 2'b01;
    repeat (520) step();
    req = 2'b00;
    repeat (2) step();

    // Randomized traffic
    repeat (3000) begin
      rand_drive();
      step();
    end
    req  = 2'b00;
    full = 1'b0;
    repeat (3) step();

    // Asynchronous reset while a grant pulse is high
    set_data(0, 4'h9);
    set_data(1, 4'h6);
    req  = 2'b11;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      step();
      if (gnt != '0) seen = 1'b1;
    end
    if (!seen) begin
      chk("gnt_wait_timeout", 0, 1);
    end else begin
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("async_rst_gnt", int'(gnt), 0);
      chk("async_rst_wr_en", int'(wr_en), 0);
      chk("async_rst_stall", int'(stall), 0);
      chk("async_rst_count", int'(wr_count), 0);
    end
    req = 2'b00;
    step();
    step();
    exp_q.delete();
    reset = 1'b0;
    set_data(1, 4'hC);
    req = 2'b10;
    repeat (3) step();
    req = 2'b00;
    repeat (3) step();

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of sync_fifo. It samples requester handshakes and honours the FIFO full flag. It drives sync_fifo wr_en/data_in with single-cycle, registered write pulses, and keeps a wrapping count of accepted writes for the 7-segment display path. The read side of the FIFO is not touched.

Parameters:
NUM_REQ, 2, number of producer ports (2..4)
DATA_W, 4, FIFO data width
WCNT_W, 8, width of the accepted-write counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-producer write request; level, held until gnt
req_data  input  NUM_REQ*DATA_W  packed producer data; slice i = req_data[i*DATA_W +: DATA_W]
fifo_full  input  1  full flag from sync_fifo
gnt  output  NUM_REQ  one-hot, one-cycle grant pulse; data of that port is written in the same cycle
fifo_wr_en  output  1  write strobe to sync_fifo
fifo_data_in  output  DATA_W  write data to sync_fifo
stall  output  1  high while at least one req is pending and fifo_full=1
wr_count  output  WCNT_W  number of accepted writes, wraps at 2^WCNT_W

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately, independent of clk:
  - gnt=0, fifo_wr_en=0, fifo_data_in=0, stall=0, wr_count=0.
  - State = IDLE; round-robin pointer = 0, so req[0] has top priority first.
- All outputs are registered; there are no combinational paths from input to output.
- FSM has 3 states: IDLE, GRANT, STALL.
- IDLE, evaluated at each rising edge:
  - No req set: stay in IDLE.
  - Any req set and fifo_full=0: choose winner w = first set req scanning from the pointer upward, wrapping at NUM_REQ-1→0.
    - On the next edge: gnt[w]=1, fifo_wr_en=1, fifo_data_in = req_data slice w as sampled at the decision edge.
    - Pointer becomes (w+1) mod NUM_REQ.
    - wr_count increments by 1.
    - Go to GRANT.
  - Any req set and fifo_full=1: go to STALL; stall=1 from the next cycle.
- GRANT:
  - Lasts exactly 1 cycle; gnt and fifo_wr_en are high only in this cycle.
  - No arbitration takes place in this cycle; always return to IDLE.
  - Maximum throughput is therefore 1 write per 2 cycles. This guarantees fifo_full reflects the previous write before the next decision.
- Requester handshake:
  - A requester must hold req and its data stable until it sees its gnt.
  - It may drop req in the cycle after gnt, or keep req high to request another write.
  - A req dropped before the decision edge is simply not seen; no grant is issued for it.
- STALL:
  - stall=1, no grants.
  - fifo_full=0 and req pending: arbitrate exactly as in IDLE (grant on next edge, stall falls with it), go to GRANT.
  - All req dropped: stall=0, go to IDLE.
- A grant is never issued while the sampled fifo_full=1, so no write is ever lost or overflowed.
- wr_count wraps from 2^WCNT_W-1 to 0 without a flag.
- Reset asserted during GRANT kills the write pulse immediately. The FIFO may or may not capture it depending on edge alignment; after reset the FIFO is cleared by its own reset anyway.
- Illegal or unused state encodings return to IDLE.

Optional Feature:
Macro FIFO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (req[0] highest); the pointer register is removed and stays 0.
- Undefined: round-robin as described under Behaviour.
- Everything else is identical in both builds.

Test Plan:
1. Assert reset mid-run with gnt high → gnt, fifo_wr_en, stall and wr_count go to 0 before the next clk edge; after release, req[1] alone is granted normally.
2. req[0]=1 with data 4'h5, fifo_full=0, sampled at edge N → at edge N+1: gnt=2'b01, fifo_wr_en=1, fifo_data_in=4'h5, wr_count=1; at edge N+2: gnt=0.
3. req=2'b11 held continuously, data0=4'h3, data1=4'hA → gnt sequence 01,00,10,00,01...; fifo_data_in alternates 3 and A; after 4 grants, wr_count=4.
4. fifo_full=1 and req[1]=1 for 5 cycles → stall=1, gnt=0 throughout; fifo_full drops at edge M → gnt=2'b10 at edge M+1 and stall=0 from the same edge.
5. Preload wr_count to 255 via 255 grants, then one more grant → wr_count=0.
6. Build with FIFO_ARB_FIXED_PRIO_EN, req=2'b11 held → every grant is gnt=2'b01; req[1] is granted only after req[0] drops.
